nn_eval_sequencer: RTL and testbench
====================================

Name: nn_eval_sequencer

Overview:
Controller that owns the 2-2-1 XOR network datapath instance. It holds the nine weight/bias registers behind a config write port and accepts (A,B) evaluation requests on a valid/ready handshake. It holds operands stable to the datapath for a fixed pipeline latency, captures result and exception flags, and returns them on a valid/ready output. It also keeps a sticky exception register for software.

Parameters:
exp_width, 8, exponent width of FP words
mant_width, 24, mantissa width incl. hidden bit; word width W = exp_width+mant_width
NN_LATENCY, 3, cycles from operands stable at datapath to valid result; legal range 1..15

Ports:
clk  in  1  clock, rising edge
rst_l  in  1  asynchronous active-low reset
cfg_we  in  1  config write strobe
cfg_addr  in  4  weight index: 0 w11, 1 w12, 2 w21, 3 w22, 4 b1, 5 b2, 6 w31, 7 w32, 8 b3
cfg_wdata  in  W  config write data
cfg_ready  out  1  config write accepted this cycle when high
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid&in_ready
in_a  in  W  operand A
in_b  in  W  operand B
in_round_mode  in  3  rounding mode for this request
out_valid  out  1  result valid
out_ready  in  1  consumer ready
out_result  out  W  captured network output
out_exceptions  out  5  exceptions captured with out_result
sticky_exc  out  5  OR of all captured exceptions since last clear
exc_clear  in  1  clear sticky_exc
nn_weights  out  9*W  weight regs to datapath; index k at [k*W +: W]
nn_a  out  W  operand A to datapath
nn_b  out  W  operand B to datapath
nn_round_mode  out  3  round mode to datapath
nn_result  in  W  datapath output
nn_exceptions  in  5  datapath exception flags
busy  out  1  high in EVAL or DONE

Behaviour:
- Reset (async, any time incl. mid-transaction): state IDLE. All weight regs, nn_a, nn_b, nn_round_mode, out_result, out_exceptions, sticky_exc and the counter go to 0. out_valid=0, busy=0. Any in-flight transaction is dropped. in_ready/cfg_ready are combinational and read 1 in IDLE.
- FSM states: IDLE, EVAL, DONE.
- IDLE:
  - cfg_ready=1.
  - in_ready = ~cfg_we. Config has priority in the same cycle.
  - Write when cfg_we. If cfg_addr<=8, the reg is updated at the edge. Addresses 9..15 are a no-op but still consume the cycle.
  - Accept when in_valid&in_ready in cycle T. nn_a, nn_b, nn_round_mode latch at the edge ending T. cnt loads NN_LATENCY. Go to EVAL.
- EVAL:
  - cnt decrements each cycle.
  - In cycle T+NN_LATENCY (cnt==1), nn_result and nn_exceptions are sampled at the closing edge into out_result and out_exceptions. sticky_exc is updated. Go to DONE.
  - out_valid first high in cycle T+NN_LATENCY+1.
- DONE:
  - out_valid=1, with out_result and out_exceptions held stable while out_ready=0.
  - On out_valid&out_ready, go to IDLE. in_ready is high from the next cycle; there is no bypass.
  - Throughput is one request per NN_LATENCY+2 cycles minimum.
- In EVAL/DONE: cfg_ready=0 and in_ready=0. cfg_we is ignored (write lost, no state change). Weights and operands are therefore stable for the whole evaluation.
- nn_a, nn_b and nn_round_mode hold their last value between transactions.
- sticky_exc next value = (exc_clear ? 0 : sticky_exc) | (capture ? nn_exceptions : 0). On simultaneous clear and capture, the new bits survive.
- No arithmetic on data words. Values pass through unchanged. The counter is 4 bits and does not wrap.

Test Plan:
1. Reset: pulse rst_l low mid-cycle -> all outputs 0 immediately (async). After release: in_ready=1, cfg_ready=1, busy=0.
2. Config write:
   - cfg_we, addr 0, data 0x40A00000 -> nn_weights[31:0]=0x40A00000 next cycle.
   - addr 12 -> nn_weights unchanged.
   - cfg_we and in_valid in the same cycle -> in_ready=0, write applied, request taken the following cycle.
3. Single eval, NN_LATENCY=3, stub datapath returns 0x3F7AE148:
   - Handshake at T with A=0x3F800000, B=0x00000000 -> nn_a=0x3F800000 from T+1.
   - out_valid rises at T+4 with out_result=0x3F7AE148.
   - in_ready low T+1 through the out handshake cycle.
4. Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid, out_result, out_exceptions stable. cfg_we to addr 8 during this window -> b3 register unchanged, cfg_ready=0.
5. Exceptions:
   - Stub flags 5'b00001 then 5'b10000 on two transactions -> sticky_exc=5'b10001.
   - exc_clear in the capture cycle of a third transaction with flags 5'b00100 -> sticky_exc=5'b00100.
6. Mid-op reset: assert rst_l=0 in cycle T+2 of EVAL -> out_valid stays 0, weights read 0. After release, a new request completes normally with the correct latency.

Source files
------------

// File: rtl/nn_eval_sequencer_if.sv
// Request, response and config handshake bundle for the XOR-network evaluation sequencer.
// The slave side belongs to the sequencer. The master side belongs to whoever issues requests.
interface nn_eval_sequencer_if #(
  parameter int W = 32
);
  logic         cfg_we;
  logic [3:0]   cfg_addr;
  logic [W-1:0] cfg_wdata;
  logic         cfg_ready;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [2:0]   in_round_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic [4:0]   out_exceptions;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, in_valid, in_a, in_b, in_round_mode, out_ready,
    input  cfg_ready, in_ready, out_valid, out_result, out_exceptions
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, in_valid, in_a, in_b, in_round_mode, out_ready,
    output cfg_ready, in_ready, out_valid, out_result, out_exceptions
  );
endinterface

// File: rtl/nn_eval_sequencer.sv
// Sequencer for the 2-2-1 XOR network datapath. It owns the weight and bias registers, holds operands
// stable for a fixed latency, captures the result and flags, and keeps a sticky exception register.
module nn_eval_sequencer #(
  parameter int exp_width  = 8,
  parameter int mant_width = 24,
  parameter int NN_LATENCY = 3,
  localparam int W = exp_width + mant_width
) (
  input  logic             clk,
  input  logic             rst_l,
  nn_eval_sequencer_if.slave bus,
  input  logic             exc_clear,
  output logic [4:0]       sticky_exc,
  output logic [9*W-1:0]   nn_weights,
  output logic [W-1:0]     nn_a,
  output logic [W-1:0]     nn_b,
  output logic [2:0]       nn_round_mode,
  input  logic [W-1:0]     nn_result,
  input  logic [4:0]       nn_exceptions,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t       state;
  logic [3:0]   cnt;
  logic [W-1:0] weights [9];

  for (genvar k = 0; k < 9; k++) begin : g_w
    assign nn_weights[k*W +: W] = weights[k];
  end

  // A config write takes priority over a request that arrives in the same cycle.
  assign bus.cfg_ready = (state == IDLE);
  assign bus.in_ready  = (state == IDLE) && !bus.cfg_we;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state              <= IDLE;
      cnt                <= '0;
      weights            <= '{default: '0};
      nn_a               <= '0;
      nn_b               <= '0;
      nn_round_mode      <= '0;
      bus.out_valid      <= 1'b0;
      bus.out_result     <= '0;
      bus.out_exceptions <= '0;
      sticky_exc         <= '0;
      busy               <= 1'b0;
    end else begin
      if (exc_clear)
        sticky_exc <= '0;
      case (state)
        IDLE: begin
          if (bus.cfg_we) begin
            if (bus.cfg_addr <= 4'd8)
              weights[bus.cfg_addr] <= bus.cfg_wdata;
          end else if (bus.in_valid) begin
            nn_a          <= bus.in_a;
            nn_b          <= bus.in_b;
            nn_round_mode <= bus.in_round_mode;
            cnt           <= 4'(NN_LATENCY);
            busy          <= 1'b1;
            state         <= EVAL;
          end
        end
        EVAL: begin
          cnt <= cnt - 4'd1;
          // When cnt is 1, the datapath output has been valid for the full latency.
          if (cnt == 4'd1) begin
            bus.out_result     <= nn_result;
            bus.out_exceptions <= nn_exceptions;
            sticky_exc         <= (exc_clear ? 5'd0 : sticky_exc) | nn_exceptions;
            bus.out_valid      <= 1'b1;
            state              <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_eval_sequencer.sv
// Bench for nn_eval_sequencer. A stub datapath stands in for the network, and a transaction-level
// reference model tracks the weights, the expected result and flags, and the sticky register.
module tb_nn_eval_sequencer;

  localparam int L = 3;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_l;
  logic           exc_clear;
  logic [4:0]     sticky_exc;
  logic [9*W-1:0] nn_weights;
  logic [W-1:0]   nn_a, nn_b;
  logic [2:0]     nn_round_mode;
  logic [W-1:0]   nn_result;
  logic [4:0]     nn_exceptions;
  logic           busy;

  nn_eval_sequencer_if #(.W(W)) bus ();

  nn_eval_sequencer #(.exp_width(8), .mant_width(24), .NN_LATENCY(L)) dut (
    .clk           (clk),
    .rst_l         (rst_l),
    .bus           (bus.slave),
    .exc_clear     (exc_clear),
    .sticky_exc    (sticky_exc),
    .nn_weights    (nn_weights),
    .nn_a          (nn_a),
    .nn_b          (nn_b),
    .nn_round_mode (nn_round_mode),
    .nn_result     (nn_result),
    .nn_exceptions (nn_exceptions),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub datapath. Mode 0 returns fixed values. Mode 1 returns a function of the operands,
  // the selected weight and the current cycle, so that a capture in the wrong cycle is detected.
  bit          stub_mode;
  logic [31:0] stub_fixed;
  logic [4:0]  stub_exc;

  function automatic logic [31:0] salt(int c);
    return c * 32'h01000193;
  endfunction

  function automatic logic [4:0] exc_of(int c);
    return (c % 3 == 0) ? 5'(1 << (c % 5)) : 5'd0;
  endfunction

  always_comb begin
    if (stub_mode) begin
      nn_result     = nn_a ^ {nn_b[15:0], nn_b[31:16]}
                      ^ nn_weights[int'(nn_round_mode)*32 +: 32] ^ salt(cyc);
      nn_exceptions = exc_of(cyc);
    end else begin
      nn_result     = stub_fixed;
      nn_exceptions = stub_exc;
    end
  end

  // Reference model state
  logic [31:0] w_model [9];
  logic [4:0]  sticky_m;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [287:0] pack_w();
    logic [287:0] p;
    for (int k = 0; k < 9; k++) p[k*32 +: 32] = w_model[k];
    return p;
  endfunction

  function automatic logic [31:0] ref_res(logic [31:0] a, logic [31:0] b, logic [2:0] rm, int c);
    return a ^ {b[15:0], b[31:16]} ^ w_model[rm] ^ salt(c);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 9; k++) w_model[k] = '0;
    sticky_m = '0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_weights"}, nn_weights, '0);
    chk({tag, "_nn_a"}, nn_a, '0);
    chk({tag, "_nn_b"}, nn_b, '0);
    chk({tag, "_rm"}, nn_round_mode, '0);
    chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
    chk({tag, "_out_result"}, bus.out_result, '0);
    chk({tag, "_out_exc"}, bus.out_exceptions, '0);
    chk({tag, "_sticky"}, sticky_exc, '0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic cfg_write(input logic [3:0] addr, input logic [31:0] data);
    bus.cfg_we = 1'b1; bus.cfg_addr = addr; bus.cfg_wdata = data;
    #1 chk("cfg_in_ready_low", bus.in_ready, 1'b0);
    chk("cfg_ready_idle", bus.cfg_ready, 1'b1);
    step();
    bus.cfg_we = 1'b0;
    if (addr <= 4'd8) w_model[addr] = data;
    chk("cfg_weights", nn_weights, pack_w());
  endtask

  // Issues one request in the current (idle) cycle and follows it through to the output handshake.
  task automatic do_eval(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                         input int stall, input bit clr, input bit poke);
    int tcyc, k;
    logic [31:0] exp_res;
    logic [4:0]  exp_exc;
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_round_mode = rm;
    #1 chk("req_in_ready", bus.in_ready, 1'b1);
    tcyc    = cyc;
    exp_res = stub_mode ? ref_res(a, b, rm, tcyc + L) : stub_fixed;
    exp_exc = stub_mode ? exc_of(tcyc + L) : stub_exc;
    step();
    bus.in_valid = 1'b0;
    chk("op_nn_a", nn_a, a);
    chk("op_nn_b", nn_b, b);
    chk("op_nn_rm", nn_round_mode, rm);
    chk("eval_busy", busy, 1'b1);
    k = 1;
    while (bus.out_valid !== 1'b1 && k < 40) begin
      chk("eval_in_ready", bus.in_ready, 1'b0);
      if (k == L) exc_clear = clr;
      step();
      exc_clear = 1'b0;
      k++;
    end
    chk("latency", k, L + 1);
    sticky_m = (clr ? 5'd0 : sticky_m) | exp_exc;
    chk("out_result", bus.out_result, exp_res);
    chk("out_exc", bus.out_exceptions, exp_exc);
    chk("sticky", sticky_exc, sticky_m);
    for (int s = 0; s < stall; s++) begin
      bus.out_ready = 1'b0;
      if (poke) begin
        bus.cfg_we = 1'b1; bus.cfg_addr = 4'd8; bus.cfg_wdata = $urandom;
      end
      #1 chk("stall_cfg_ready", bus.cfg_ready, 1'b0);
      chk("stall_in_ready", bus.in_ready, 1'b0);
      step();
      bus.cfg_we = 1'b0;
      chk("stall_valid", bus.out_valid, 1'b1);
      chk("stall_result", bus.out_result, exp_res);
      chk("stall_exc", bus.out_exceptions, exp_exc);
    end
    bus.out_ready = 1'b1;
    #1 chk("hs_in_ready", bus.in_ready, 1'b0);
    step();
    bus.out_ready = 1'b0;
    chk("post_valid", bus.out_valid, 1'b0);
    chk("post_busy", busy, 1'b0);
    chk("post_in_ready", bus.in_ready, 1'b1);
    chk("post_weights", nn_weights, pack_w());
  endtask

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic        in_valid;
    logic        exp_in_ready;
    logic        exp_change;
  } cfg_vec_t;

  cfg_vec_t cv [8];

  initial begin
    #200000;
    $display("FAIL timeout actual=%0d expected=%0d", cyc, 0);
    $fatal(1, "timeout");
  end

  initial begin
    rst_l = 1'b0; exc_clear = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_round_mode = '0;
    bus.out_ready = 1'b0;
    stub_mode = 1'b0; stub_fixed = 32'h3F7AE148; stub_exc = 5'd0;
    model_reset();

    cv[0] = '{4'd0,  32'h40A00000, 1'b0, 1'b0, 1'b1};
    cv[1] = '{4'd12, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
    cv[2] = '{4'd4,  32'hBF800000, 1'b1, 1'b0, 1'b1};
    cv[3] = '{4'd9,  32'h12345678, 1'b1, 1'b0, 1'b0};
    cv[4] = '{4'd8,  32'h3E99999A, 1'b0, 1'b0, 1'b1};
    cv[5] = '{4'd15, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    cv[6] = '{4'd6,  32'h41200000, 1'b1, 1'b0, 1'b1};
    cv[7] = '{4'd3,  32'hC0400000, 1'b0, 1'b0, 1'b1};

    repeat (2) step();
    check_reset_state("rst_init");
    rst_l = 1'b1;
    step();
    chk("rel_in_ready", bus.in_ready, 1'b1);
    chk("rel_cfg_ready", bus.cfg_ready, 1'b1);
    chk("rel_busy", busy, 1'b0);

    // Config writes from the vector table. A request alongside must not be taken.
    for (int i = 0; i < 8; i++) begin
      bus.cfg_we = 1'b1; bus.cfg_addr = cv[i].addr; bus.cfg_wdata = cv[i].data;
      bus.in_valid = cv[i].in_valid;
      #1 chk("tbl_in_ready", bus.in_ready, cv[i].exp_in_ready);
      chk("tbl_cfg_ready", bus.cfg_ready, 1'b1);
      step();
      bus.cfg_we = 1'b0; bus.in_valid = 1'b0;
      if (cv[i].exp_change) w_model[cv[i].addr] = cv[i].data;
      chk("tbl_weights", nn_weights, pack_w());
      chk("tbl_busy", busy, 1'b0);
    end
    chk("w11_value", nn_weights[31:0], 32'h40A00000);

    // A write and a request in the same cycle: the write wins, and the request goes next cycle.
    bus.in_valid = 1'b1; bus.in_a = 32'h3F800000; bus.in_b = 32'h3F800000;
    cfg_write(4'd1, 32'h3F000000);
    do_eval(32'h3F800000, 32'h3F800000, 3'd0, 0, 1'b0, 1'b0);

    // Single evaluation against the fixed stub
    do_eval(32'h3F800000, 32'h00000000, 3'd2, 0, 1'b0, 1'b0);

    // Backpressure with a config write attempt to b3
    do_eval(32'h40000000, 32'h40400000, 3'd1, 5, 1'b0, 1'b1);

    // Sticky exceptions, then a clear in the capture cycle
    stub_exc = 5'b00001; do_eval(32'h1, 32'h2, 3'd0, 0, 1'b0, 1'b0);
    stub_exc = 5'b10000; do_eval(32'h3, 32'h4, 3'd0, 1, 1'b0, 1'b0);
    chk("sticky_or", sticky_exc, 5'b10001);
    stub_exc = 5'b00100; do_eval(32'h5, 32'h6, 3'd0, 0, 1'b1, 1'b0);
    chk("sticky_clr_cap", sticky_exc, 5'b00100);
    stub_exc = 5'b00000;

    // Asynchronous reset in the middle of a cycle
    #2 rst_l = 1'b0;
    #1 check_reset_state("rst_async");
    step();
    rst_l = 1'b1;
    model_reset();
    step();
    chk("rst2_in_ready", bus.in_ready, 1'b1);

    // Reset during EVAL drops the transaction
    cfg_write(4'd2, 32'hAAAA5555);
    bus.in_valid = 1'b1; bus.in_a = 32'h77; bus.in_b = 32'h88; bus.in_round_mode = 3'd1;
    step();
    bus.in_valid = 1'b0;
    step();
    rst_l = 1'b0;
    #1 chk("midrst_weights", nn_weights, '0);
    chk("midrst_valid", bus.out_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    repeat (L + 2) begin
      step();
      chk("midrst_hold_valid", bus.out_valid, 1'b0);
    end
    rst_l = 1'b1;
    model_reset();
    step();
    do_eval(32'h3F800000, 32'h3F800000, 3'd3, 0, 1'b0, 1'b0);

    // Randomized traffic against the model
    stub_mode = 1'b1;
    for (int it = 0; it < 40; it++) begin
      int idle_n;
      idle_n = $urandom_range(0, 3);
      for (int j = 0; j < idle_n; j++) begin
        case ($urandom_range(0, 2))
          0: cfg_write(4'($urandom_range(0, 15)), $urandom);
          1: begin
            exc_clear = 1'b1;
            step();
            exc_clear = 1'b0;
            sticky_m = '0;
            chk("rand_idle_clr", sticky_exc, sticky_m);
          end
          default: step();
        endcase
      end
      do_eval($urandom, $urandom, 3'($urandom_range(0, 7)), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
